// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and helpers for the miniRV memory access unit.
package mem_pkg;

    localparam logic [2:0] RW_SB = 3'b000;
    localparam logic [2:0] RW_SH = 3'b001;
    localparam logic [2:0] RW_SW = 3'b010;
    localparam logic [2:0] RW_SD = 3'b011;
    localparam logic [2:0] RW_UB = 3'b100;
    localparam logic [2:0] RW_UH = 3'b101;
    localparam logic [2:0] RW_UW = 3'b110;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_RESP
    } mem_state_e;

    function automatic logic [3:0] size_bytes(input logic [2:0] op);
        return 4'd1 << op[1:0];
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane extract/extend for loads; lane merge, shift and strobes for stores.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OW = $clog2(NB)
) (
    input  logic [2:0]      op,
    input  logic [OW-1:0]   off,
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] base,
    output logic [XLEN-1:0] ld_data,
    output logic [XLEN-1:0] st_merge,
    output logic [XLEN-1:0] st_shift,
    output logic [NB-1:0]   st_strb
);

    int sb;
    logic sgn;
    logic [XLEN-1:0] sh_r;
    logic [XLEN-1:0] sh_w;

    always_comb begin
        sb = int'(size_bytes(op));
        if (sb > NB) sb = NB;
        sh_r = rdata >> {off, 3'b000};
        sh_w = wdata << {off, 3'b000};
        sgn = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (i == sb - 1) sgn = sh_r[8*i+7];
        end
        sgn = sgn & ~op[2];
        ld_data  = '0;
        st_merge = '0;
        st_shift = '0;
        st_strb  = '0;
        // bytes above the access size take the sign; lane bytes take wdata
        for (int i = 0; i < NB; i++) begin
            ld_data[8*i+:8] = (i < sb) ? sh_r[8*i+:8] : {8{sgn}};
            st_strb[i] = (i >= int'(off)) && (i < int'(off) + sb);
            st_shift[8*i+:8] = st_strb[i] ? sh_w[8*i+:8] : 8'h00;
            st_merge[8*i+:8] = st_strb[i] ? sh_w[8*i+:8] : base[8*i+:8];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Sequential load/store unit: one access per handshake over a variable-latency DRAM port.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int USE_BYTE_EN = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_rw_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_misalign,
    output logic                stall,
    output logic                dram_req_valid,
    input  logic                dram_req_ready,
    output logic                dram_we,
    output logic [ADDR_W-1:0]   dram_addr,
    output logic [XLEN-1:0]     dram_wdata,
    output logic [XLEN/8-1:0]   dram_wstrb,
    input  logic                dram_rvalid,
    input  logic [XLEN-1:0]     dram_rdata
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    mem_state_e state_q, state_d;
    logic              we_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   word_q;
    logic [XLEN-1:0]   res_q;
    logic              mis_q;

    logic            accept;
    logic            mis;
    logic            full_w;
    logic            in_rd;
    logic            in_wr;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] st_merge;
    logic [XLEN-1:0] st_shift;
    logic [NB-1:0]   st_strb;

    assign accept = req_valid && (state_q == ST_IDLE);
    assign full_w = int'(size_bytes(req_rw_op)) == NB;

    always_comb begin
        mis = 1'b0;
        unique case (req_rw_op[1:0])
            SZ_B: mis = 1'b0;
            SZ_H: mis = req_addr[0];
            SZ_W: mis = |req_addr[1:0];
            SZ_D: mis = (XLEN == 32) || (|req_addr[2:0]);
            default: mis = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (mis) state_d = ST_RESP;
                    else if (!req_we) state_d = ST_RD_REQ;
                    else if (USE_BYTE_EN != 0 || full_w) state_d = ST_WR_REQ;
                    else state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ:  if (dram_req_ready) state_d = ST_RD_WAIT;
            ST_RD_WAIT: if (dram_rvalid) state_d = we_q ? ST_WR_REQ : ST_RESP;
            ST_WR_REQ:  if (dram_req_ready) state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            res_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                op_q    <= req_rw_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                mis_q   <= mis;
                res_q   <= '0;
            end
            if (state_q == ST_RD_WAIT && dram_rvalid) begin
                word_q <= dram_rdata;
                if (!we_q) res_q <= ld_data;
            end
        end
    end

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .op       (op_q),
        .off      (addr_q[OW-1:0]),
        .rdata    (dram_rdata),
        .wdata    (wdata_q),
        .base     (word_q),
        .ld_data  (ld_data),
        .st_merge (st_merge),
        .st_shift (st_shift),
        .st_strb  (st_strb)
    );

    assign in_rd = state_q == ST_RD_REQ;
    assign in_wr = state_q == ST_WR_REQ;

    assign req_ready      = state_q == ST_IDLE;
    assign stall          = state_q != ST_IDLE;
    assign resp_valid     = state_q == ST_RESP;
    assign resp_rdata     = res_q;
    assign resp_misalign  = mis_q;
    assign dram_req_valid = in_rd || in_wr;
    assign dram_we        = in_wr;
    // latched request fields keep the DRAM bus stable while ready is low
    assign dram_addr  = (in_rd || in_wr) ? {addr_q[ADDR_W-1:OW], {OW{1'b0}}} : '0;
    assign dram_wdata = !in_wr ? '0 : (USE_BYTE_EN != 0) ? st_shift : st_merge;
    assign dram_wstrb = !in_wr ? '0 : (USE_BYTE_EN != 0) ? st_strb : '1;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench over three configurations: 32b RMW, 32b byte strobes, 64b RMW.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int          sel = 0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_rw_op = 3'b0;
    logic [31:0] req_addr = 32'h0;
    logic [63:0] req_wdata = 64'h0;
    logic        dram_ready = 1'b1;
    logic        rv_auto = 1'b0;
    logic        rv_man = 1'b0;
    logic        hold_rv = 1'b0;
    logic [63:0] mem_word = 64'h0;
    logic        dram_rvalid;
    assign dram_rvalid = rv_auto | rv_man;

    logic a_req_ready, a_resp_valid, a_resp_misalign, a_stall, a_dram_req_valid, a_dram_we;
    logic [31:0] a_resp_rdata, a_dram_addr, a_dram_wdata;
    logic [3:0]  a_dram_wstrb;
    logic b_req_ready, b_resp_valid, b_resp_misalign, b_stall, b_dram_req_valid, b_dram_we;
    logic [31:0] b_resp_rdata, b_dram_addr, b_dram_wdata;
    logic [3:0]  b_dram_wstrb;
    logic c_req_ready, c_resp_valid, c_resp_misalign, c_stall, c_dram_req_valid, c_dram_we;
    logic [63:0] c_resp_rdata, c_dram_wdata;
    logic [31:0] c_dram_addr;
    logic [7:0]  c_dram_wstrb;

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .USE_BYTE_EN(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && sel == 0), .req_ready(a_req_ready),
        .req_we(req_we), .req_rw_op(req_rw_op), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
        .resp_misalign(a_resp_misalign), .stall(a_stall),
        .dram_req_valid(a_dram_req_valid), .dram_req_ready(dram_ready),
        .dram_we(a_dram_we), .dram_addr(a_dram_addr),
        .dram_wdata(a_dram_wdata), .dram_wstrb(a_dram_wstrb),
        .dram_rvalid(dram_rvalid), .dram_rdata(mem_word[31:0])
    );

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .USE_BYTE_EN(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && sel == 1), .req_ready(b_req_ready),
        .req_we(req_we), .req_rw_op(req_rw_op), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
        .resp_misalign(b_resp_misalign), .stall(b_stall),
        .dram_req_valid(b_dram_req_valid), .dram_req_ready(dram_ready),
        .dram_we(b_dram_we), .dram_addr(b_dram_addr),
        .dram_wdata(b_dram_wdata), .dram_wstrb(b_dram_wstrb),
        .dram_rvalid(dram_rvalid), .dram_rdata(mem_word[31:0])
    );

    mem_access_unit #(.XLEN(64), .ADDR_W(32), .USE_BYTE_EN(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && sel == 2), .req_ready(c_req_ready),
        .req_we(req_we), .req_rw_op(req_rw_op), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(c_resp_valid), .resp_rdata(c_resp_rdata),
        .resp_misalign(c_resp_misalign), .stall(c_stall),
        .dram_req_valid(c_dram_req_valid), .dram_req_ready(dram_ready),
        .dram_we(c_dram_we), .dram_addr(c_dram_addr),
        .dram_wdata(c_dram_wdata), .dram_wstrb(c_dram_wstrb),
        .dram_rvalid(dram_rvalid), .dram_rdata(mem_word)
    );

    logic        m_req_ready, m_resp_valid, m_resp_misalign, m_stall;
    logic        m_dram_req_valid, m_dram_we;
    logic [63:0] m_resp_rdata, m_dram_wdata;
    logic [31:0] m_dram_addr;
    logic [7:0]  m_dram_wstrb;

    always_comb begin
        m_req_ready = a_req_ready;
        m_resp_valid = a_resp_valid;
        m_resp_misalign = a_resp_misalign;
        m_stall = a_stall;
        m_dram_req_valid = a_dram_req_valid;
        m_dram_we = a_dram_we;
        m_resp_rdata = {32'h0, a_resp_rdata};
        m_dram_wdata = {32'h0, a_dram_wdata};
        m_dram_addr = a_dram_addr;
        m_dram_wstrb = {4'h0, a_dram_wstrb};
        case (sel)
            1: begin
                m_req_ready = b_req_ready;
                m_resp_valid = b_resp_valid;
                m_resp_misalign = b_resp_misalign;
                m_stall = b_stall;
                m_dram_req_valid = b_dram_req_valid;
                m_dram_we = b_dram_we;
                m_resp_rdata = {32'h0, b_resp_rdata};
                m_dram_wdata = {32'h0, b_dram_wdata};
                m_dram_addr = b_dram_addr;
                m_dram_wstrb = {4'h0, b_dram_wstrb};
            end
            2: begin
                m_req_ready = c_req_ready;
                m_resp_valid = c_resp_valid;
                m_resp_misalign = c_resp_misalign;
                m_stall = c_stall;
                m_dram_req_valid = c_dram_req_valid;
                m_dram_we = c_dram_we;
                m_resp_rdata = c_resp_rdata;
                m_dram_wdata = c_dram_wdata;
                m_dram_addr = c_dram_addr;
                m_dram_wstrb = c_dram_wstrb;
            end
            default: ;
        endcase
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // DRAM model: zero-wait reads, write log, request-cycle counter
    int rd_cnt = 0;
    int wr_cnt = 0;
    int req_cycles = 0;
    logic [63:0] last_wdata = 64'h0;
    logic [7:0]  last_wstrb = 8'h0;
    logic [31:0] last_addr = 32'h0;

    always @(posedge clk) begin
        rv_auto <= 1'b0;
        if (m_dram_req_valid) req_cycles <= req_cycles + 1;
        if (m_dram_req_valid && dram_ready) begin
            last_addr <= m_dram_addr;
            if (m_dram_we) begin
                wr_cnt <= wr_cnt + 1;
                last_wdata <= m_dram_wdata;
                last_wstrb <= m_dram_wstrb;
            end else begin
                rd_cnt <= rd_cnt + 1;
                rv_auto <= !hold_rv;
            end
        end
    end

    typedef struct {
        string       tag;
        logic [63:0] rdata;
        logic        mis;
    } exp_t;
    exp_t sb_q[$];
    int resp_cnt = 0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (m_resp_valid) begin
            resp_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk({e.tag, "_rdata"}, m_resp_rdata, e.rdata);
                chk({e.tag, "_mis"}, 64'(m_resp_misalign), 64'(e.mis));
                chk({e.tag, "_stall"}, 64'(m_stall), 64'd1);
            end
        end
    end

    task automatic push_exp(input string tag, input logic [63:0] rd, input logic mis);
        exp_t e;
        e.tag = tag;
        e.rdata = rd;
        e.mis = mis;
        sb_q.push_back(e);
    endtask

    task automatic issue(input int s, input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [63:0] wd);
        @(negedge clk);
        sel = s;
        req_we = we;
        req_rw_op = op;
        req_addr = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        #1;
        chk("req_ready_idle", 64'(m_req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_resp_valid && lat < 40);
        if (!m_resp_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run(input string tag, input int s, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [63:0] wd,
                       input logic [63:0] erd, input logic emis, input int elat);
        int lat;
        push_exp(tag, erd, emis);
        issue(s, we, op, addr, wd);
        wait_resp(tag, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int rd0, wr0, rc0, rs0, lat;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(m_req_ready), 64'd1);
        chk("rst_ctl", 64'({m_stall, m_resp_valid, m_dram_req_valid, m_dram_we, m_resp_misalign}), 64'd0);
        chk("rst_addr", 64'(m_dram_addr), 64'd0);
        chk("rst_wdata", m_dram_wdata, 64'd0);
        chk("rst_wstrb", 64'(m_dram_wstrb), 64'd0);
        chk("rst_rdata", m_resp_rdata, 64'd0);
        rst_n = 1'b1;

        mem_word = 64'h8_0FF_1234 & 64'hFFFF_FFFF;
        mem_word = 64'h80FF_1234;
        run("lb",  0, 1'b0, RW_SB, 32'h1003, 64'h0, 64'hFFFF_FF80, 1'b0, 3);
        run("lbu", 0, 1'b0, RW_UB, 32'h1003, 64'h0, 64'h0000_0080, 1'b0, 3);
        run("lh",  0, 1'b0, RW_SH, 32'h1002, 64'h0, 64'hFFFF_80FF, 1'b0, 3);
        run("lhu", 0, 1'b0, RW_UH, 32'h1000, 64'h0, 64'h0000_1234, 1'b0, 3);
        run("lw",  0, 1'b0, RW_SW, 32'h1000, 64'h0, 64'h80FF_1234, 1'b0, 3);

        mem_word = 64'h1122_3344;
        rd0 = rd_cnt; wr0 = wr_cnt;
        run("sb_rmw", 0, 1'b1, RW_SB, 32'h2001, 64'hFFFF_FFAB, 64'h0, 1'b0, 4);
        chk("sb_rmw_reads", 64'(rd_cnt - rd0), 64'd1);
        chk("sb_rmw_writes", 64'(wr_cnt - wr0), 64'd1);
        chk("sb_rmw_wdata", last_wdata, 64'h1122_AB44);
        chk("sb_rmw_wstrb", 64'(last_wstrb), 64'h0F);
        chk("sb_rmw_addr", 64'(last_addr), 64'h2000);
        run("sh_rmw", 0, 1'b1, RW_SH, 32'h2002, 64'hBEEF, 64'h0, 1'b0, 4);
        chk("sh_rmw_wdata", last_wdata, 64'hBEEF_3344);
        rd0 = rd_cnt;
        run("sw_full", 0, 1'b1, RW_SW, 32'h2004, 64'hA5A5_5A5A, 64'h0, 1'b0, 2);
        chk("sw_full_reads", 64'(rd_cnt - rd0), 64'd0);
        chk("sw_full_wdata", last_wdata, 64'hA5A5_5A5A);
        chk("sw_full_wstrb", 64'(last_wstrb), 64'h0F);
        chk("sw_full_addr", 64'(last_addr), 64'h2004);

        rd0 = rd_cnt; wr0 = wr_cnt;
        run("sb_be", 1, 1'b1, RW_SB, 32'h2001, 64'hFFFF_FFAB, 64'h0, 1'b0, 2);
        chk("sb_be_reads", 64'(rd_cnt - rd0), 64'd0);
        chk("sb_be_writes", 64'(wr_cnt - wr0), 64'd1);
        chk("sb_be_wdata", last_wdata, 64'h0000_AB00);
        chk("sb_be_wstrb", 64'(last_wstrb), 64'h02);
        run("sh_be", 1, 1'b1, RW_SH, 32'h2002, 64'h1234_BEEF, 64'h0, 1'b0, 2);
        chk("sh_be_wdata", last_wdata, 64'hBEEF_0000);
        chk("sh_be_wstrb", 64'(last_wstrb), 64'h0C);

        rc0 = req_cycles;
        run("lh_mis", 0, 1'b0, RW_SH, 32'h3001, 64'h0, 64'h0, 1'b1, 1);
        run("lw_mis", 0, 1'b0, RW_SW, 32'h3002, 64'h0, 64'h0, 1'b1, 1);
        run("sw_mis", 0, 1'b1, RW_SW, 32'h3001, 64'h55, 64'h0, 1'b1, 1);
        run("ld_x32", 0, 1'b0, RW_SD, 32'h3000, 64'h0, 64'h0, 1'b1, 1);
        chk("mis_no_dram", 64'(req_cycles - rc0), 64'd0);

        dram_ready = 1'b0;
        mem_word = 64'hCAFE_F00D;
        push_exp("lw_hold", 64'hCAFE_F00D, 1'b0);
        issue(0, 1'b0, RW_SW, 32'h4000, 64'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_dvalid", 64'(m_dram_req_valid), 64'd1);
            chk("hold_addr", 64'(m_dram_addr), 64'h4000);
            chk("hold_stall", 64'(m_stall), 64'd1);
            chk("hold_ready", 64'(m_req_ready), 64'd0);
        end
        dram_ready = 1'b1;
        wait_resp("lw_hold", lat);
        chk("lw_hold_lat", 64'(lat), 64'd2);
        @(negedge clk);
        chk("idle_after", 64'({m_stall, m_req_ready}), 64'd1);

        hold_rv = 1'b1;
        rs0 = resp_cnt;
        issue(0, 1'b0, RW_SW, 32'h5000, 64'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rdwait_stall", 64'(m_stall), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(m_req_ready), 64'd1);
        chk("arst_ctl", 64'({m_stall, m_resp_valid, m_dram_req_valid, m_dram_we, m_resp_misalign}), 64'd0);
        chk("arst_addr", 64'(m_dram_addr), 64'd0);
        chk("arst_rdata", m_resp_rdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rv_man = 1'b1;
        @(negedge clk);
        rv_man = 1'b0;
        hold_rv = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_rv_noresp", 64'(resp_cnt - rs0), 64'd0);
        chk("post_rst_ready", 64'(m_req_ready), 64'd1);

        mem_word = 64'hDEADBEEF_0000_0001;
        run("lwu64", 2, 1'b0, RW_UW, 32'h6004, 64'h0, 64'h0000_0000_DEAD_BEEF, 1'b0, 3);
        run("lw64",  2, 1'b0, RW_SW, 32'h6004, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 3);
        run("ld64_mis", 2, 1'b0, RW_SD, 32'h6004, 64'h0, 64'h0, 1'b1, 1);
        run("ld64",  2, 1'b0, RW_SD, 32'h6000, 64'h0, 64'hDEAD_BEEF_0000_0001, 1'b0, 3);
        run("lw64_lo", 2, 1'b0, RW_SW, 32'h6000, 64'h0, 64'h1, 1'b0, 3);
        run("sw64_rmw", 2, 1'b1, RW_SW, 32'h6004, 64'h1234_5678, 64'h0, 1'b0, 4);
        chk("sw64_wdata", last_wdata, 64'h1234_5678_0000_0001);
        chk("sw64_wstrb", 64'(last_wstrb), 64'hFF);
        chk("sw64_addr", 64'(last_addr), 64'h6000);
        run("sd64", 2, 1'b1, RW_SD, 32'h6008, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 2);
        chk("sd64_wdata", last_wdata, 64'h0123_4567_89AB_CDEF);
        chk("sd64_addr", 64'(last_addr), 64'h6008);

        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sequential memory-stage access unit for the miniRV pipeline; successor to the combinational load/store lane logic.
- Takes one load/store per handshake and drives a handshaked DRAM port with variable latency.
- Performs byte/half/word (and double when XLEN=64) extraction, sign or zero extension, and sub-word store merge, either by read-modify-write or by byte strobes.
- Detects misaligned accesses and holds the pipeline stalled while busy.

Parameters:
- XLEN, 32: data width, 32 or 64.
- ADDR_W, 32: address width.
- USE_BYTE_EN, 0: 0 = sub-word stores use read-modify-write; 1 = single write with byte strobes.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  pipeline presents an access.
- req_ready  out  1  unit can accept an access (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_rw_op  in  3  [1:0] size (00 B, 01 H, 10 W, 11 D); [2] = 1 means unsigned load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores.
- resp_misalign  out  1  qualifies resp_valid; access was misaligned.
- stall  out  1  high whenever state != IDLE.
- dram_req_valid  out  1  DRAM request.
- dram_req_ready  in  1  DRAM accepts the request.
- dram_we  out  1  DRAM write.
- dram_addr  out  ADDR_W  word-aligned address; low log2(XLEN/8) bits are 0.
- dram_wdata  out  XLEN  full-word write data.
- dram_wstrb  out  XLEN/8  byte strobes.
- dram_rvalid  in  1  read data valid.
- dram_rdata  in  XLEN  read word.

Behaviour:
- Reset: state = IDLE. All outputs are 0 except req_ready = 1. Assertion takes effect immediately, including mid-transaction; dram_req_valid drops at once and in-flight DRAM responses are aborted.
- Accept: on req_valid && req_ready, latch we, rw_op, addr and wdata. req_ready is 1 only in IDLE.
- Misalignment check: size H needs addr[0] = 0; W needs addr[1:0] = 0; D needs addr[2:0] = 0.
  - Size D when XLEN = 32 is treated as misaligned.
  - A misaligned access goes to RESP with resp_misalign = 1 and generates no DRAM traffic.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
  - Load: IDLE → RD_REQ → RD_WAIT → RESP.
  - Full-width store, or any store when USE_BYTE_EN = 1: IDLE → WR_REQ → RESP.
  - Sub-word store with USE_BYTE_EN = 0: IDLE → RD_REQ → RD_WAIT → WR_REQ → RESP.
  - RESP → IDLE unconditionally.
- DRAM request rules: in RD_REQ and WR_REQ, dram_req_valid = 1. dram_addr, dram_we, dram_wdata and dram_wstrb stay stable until dram_req_ready, then the FSM advances.
- Read return: dram_rdata is captured on dram_rvalid in RD_WAIT only; dram_rvalid in any other state is ignored.
- Load result: lane selected by the low address bits, extended per rw_op[2]. Full-width loads pass unchanged.
- Store, USE_BYTE_EN = 0: the captured word with the addressed lane replaced by wdata; wstrb = all ones.
- Store, USE_BYTE_EN = 1: wdata shifted into its lane with other bytes 0; wstrb set only on the written bytes.
- Response: resp_valid is a 1-cycle pulse in RESP. resp_rdata and resp_misalign hold their values until the next accept.
- Minimum latency, accept to resp_valid:
  - Misaligned access: 1 cycle.
  - Store with immediate ready: 2 cycles.
  - Load with 0-wait DRAM: 3 cycles.
- stall = (state != IDLE). A new request can be accepted in the cycle after RESP.

Decomposition:
- Package mem_pkg holds:
  - RW_SB, RW_SH, RW_SW, RW_SD, RW_UB, RW_UH, RW_UW encodings;
  - size field constants;
  - FSM state enum;
  - function size_bytes(op).
- One sub-module, mem_lane_align: combinational extract/extend plus merge and strobe generation, parametrised by XLEN.

Test Plan:
- Byte loads at 0x1003, DRAM word 0x80FF_1234, XLEN = 32:
  - LB → resp_rdata 0xFFFF_FF80.
  - LBU → resp_rdata 0x0000_0080.
- SB 0xAB at 0x2001, DRAM word 0x1122_3344:
  - USE_BYTE_EN = 0 → read, then write 0x1122_AB44 with wstrb 4'hF.
  - USE_BYTE_EN = 1 → single write 0x0000_AB00 with wstrb 4'b0010.
- LH at 0x3001 → resp_misalign = 1 on the cycle after accept; dram_req_valid never asserted.
- dram_req_ready held low 5 cycles on a load → dram_req_valid and dram_addr stable throughout; stall = 1 until resp_valid; req_ready = 0 throughout.
- rst_n low in RD_WAIT → all outputs 0 and req_ready = 1 immediately; a late dram_rvalid after release produces no resp_valid.
- XLEN = 64, DRAM word 0xDEADBEEF_0000_0001, address 0x..4:
  - LWU → 0x0000_0000_DEADBEEF.
  - LW → 0xFFFF_FFFF_DEADBEEF.
  - LD at 0x..4 → misaligned.
